// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants, types and helpers for the RX byte FIFO
package rx_pkg;

    localparam int RX_FIFO_DEPTH_LOG2 = 9;
    localparam int RX_BYTE_W          = 8;

    typedef logic [RX_BYTE_W-1:0] rx_byte_t;

    // level must count 0 .. 2**depth_log2 + 1 (RAM plus prefetch register)
    function automatic int rx_level_w(input int depth_log2);
        return depth_log2 + 2;
    endfunction

endpackage

// File: rtl/rx_fifo_ram.sv
// rtl/rx_fifo_ram.sv - simple dual-port byte RAM with registered read port
module rx_fifo_ram
    import rx_pkg::*;
#(
    parameter int ADDR_W = RX_FIFO_DEPTH_LOG2
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [RX_BYTE_W-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [RX_BYTE_W-1:0] rd_data
);

    rx_byte_t r_mem [0:(1 << ADDR_W)-1];
    rx_byte_t r_rd_data;

    // Storage and read register carry no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - first-word-fall-through byte FIFO for the RX path
module rx_byte_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                wr_en,
    input  logic [RX_BYTE_W-1:0]                wr_data,
    output logic                                full,
    input  logic                                rd_en,
    output logic [RX_BYTE_W-1:0]                q,
    output logic                                has_data,
    output logic [rx_level_w(DEPTH_LOG2)-1:0]   level,
    output logic                                overflow,
    input  logic                                ovf_clr
);

    localparam int                LVL_W    = rx_level_w(DEPTH_LOG2);
    localparam logic [LVL_W-1:0]  CAPACITY = LVL_W'((1 << DEPTH_LOG2) + 1);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic                  r_ram_full;
    logic                  r_rd_pending;
    logic                  r_has_data;
    rx_byte_t              r_q;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_wr_drop;
    logic                  w_pop;
    logic                  w_ram_nonempty;
    logic                  w_rd_issue;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_inc;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_inc;
    rx_byte_t              w_ram_q;

    // Full is decided from registered level only, so rd_en never feeds write acceptance
    assign w_full         = (r_level == CAPACITY);
    assign w_wr_accept    = wr_en && !w_full && !flush;
    assign w_wr_drop      = wr_en && w_full;
    assign w_pop          = rd_en && r_has_data && !flush;
    assign w_ram_nonempty = (r_wr_ptr != r_rd_ptr) || r_ram_full;
    // Refill the prefetch register when it is empty, or is being emptied this cycle
    assign w_rd_issue     = !flush && w_ram_nonempty && !r_rd_pending
                            && (!r_has_data || rd_en);
    assign w_wr_ptr_inc   = r_wr_ptr + DEPTH_LOG2'(1);
    assign w_rd_ptr_inc   = r_rd_ptr + DEPTH_LOG2'(1);

    rx_fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd_issue),
        .rd_addr (r_rd_ptr),
        .rd_data (w_ram_q)
    );

    // RAM pointers plus the bit that tells a full RAM from an empty one at equal pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_full <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_full <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_wr_accept && !w_rd_issue) begin
                r_ram_full <= (w_wr_ptr_inc == r_rd_ptr);
            end else if (!w_wr_accept && w_rd_issue) begin
                r_ram_full <= 1'b0;
            end
        end
    end

    // Prefetch register: a landing read loads q, a pop empties it; flush drops any read in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pending <= 1'b0;
            r_has_data   <= 1'b0;
            r_q          <= '0;
        end else if (flush) begin
            r_rd_pending <= 1'b0;
            r_has_data   <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_issue;
            if (r_rd_pending) begin
                r_q        <= w_ram_q;
                r_has_data <= 1'b1;
            end else if (w_pop) begin
                r_has_data <= 1'b0;
            end
        end
    end

    // Occupancy across RAM, in-flight read and prefetch register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else if (flush) begin
            r_level <= '0;
        end else if (w_wr_accept && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
        end else if (!w_wr_accept && w_pop) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

    // Sticky dropped-write flag; a new drop beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign full     = w_full;
    assign q        = r_q;
    assign has_data = r_has_data;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb/tb_rx_byte_fifo.sv - directed self-checking bench for rx_byte_fifo
module tb_rx_byte_fifo;

    localparam int DL2 = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       rd_en = 1'b0;
    logic [7:0] q;
    logic       has_data;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    rx_byte_fifo #(
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .q        (q),
        .has_data (has_data),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_data();
        for (int i = 0; i < 8 && !has_data; i++) begin
            tick();
        end
        chk("wait_data", has_data, 1);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        wait_data();
        chk(tag, q, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        tick();
        tick();
        tick();
        chk({tag, "_has_data"}, has_data, 0);
        chk({tag, "_level"}, level, 0);
    endtask

    initial begin
        #2;
        chk("rst_level", level, 0);
        chk("rst_has_data", has_data, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_q", q, 8'h00);
        tick();
        reset = 1'b0;
        tick();

        // fall-through latency
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("lat_e0_level", level, 1);
        chk("lat_e0_has_data", has_data, 0);
        tick();
        chk("lat_e1_has_data", has_data, 0);
        chk("lat_e1_level", level, 1);
        tick();
        chk("lat_e2_has_data", has_data, 1);
        chk("lat_e2_q", q, 8'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("lat_pop_has_data", has_data, 0);
        chk("lat_pop_level", level, 0);

        // ordering and pointer wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            wr_burst(8'h00, 9);
            chk("ord_full", full, 1);
            chk("ord_level", level, 9);
            for (int i = 0; i < 9; i++) begin
                pop_expect("ord_q", 8'(i));
            end
            chk("ord_full_after", full, 0);
            expect_empty("ord_end");
        end

        // overflow with a simultaneous pop
        wr_burst(8'h10, 9);
        wait_data();
        chk("ovf_full", full, 1);
        wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", level, 8);
        for (int i = 1; i < 9; i++) begin
            pop_expect("ovf_q", 8'h10 + 8'(i));
        end
        expect_empty("ovf_end");
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // flush while a refill read is in flight
        wr_burst(8'h40, 4);
        wait_data();
        chk("fl_q", q, 8'h40);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fl_pop_level", level, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_has_data", has_data, 0);
        chk("fl_level", level, 0);
        tick();
        tick();
        chk("fl_stale_has_data", has_data, 0);
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        chk("fl_new_has_data", has_data, 1);
        chk("fl_new_q", q, 8'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        expect_empty("fl_end");

        // pop on empty is ignored
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("emp_level", level, 0);
            chk("emp_has_data", has_data, 0);
        end
        rd_en = 1'b0;
        wr_burst(8'h51, 3);
        for (int i = 0; i < 3; i++) begin
            pop_expect("emp_q", 8'h51 + 8'(i));
        end
        expect_empty("emp_end");

        // asynchronous reset mid-operation, with the FIFO full and overflowed
        wr_burst(8'h60, 10);
        chk("ar_pre_full", full, 1);
        chk("ar_pre_ovf", overflow, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("ar_has_data", has_data, 0);
        chk("ar_level", level, 0);
        chk("ar_full", full, 0);
        chk("ar_overflow", overflow, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_after_level", level, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
